// File: rtl/spatz_vrf_reader.sv
// rtl/spatz_vrf_reader.sv - VRF read-port client streaming elements through a small output FIFO
module spatz_vrf_reader #(
    parameter int NR_REGS       = 32,
    parameter int ELEMS_PER_REG = 4,
    parameter int ELEM_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 2,
    localparam int VADDR_WIDTH  = $clog2(NR_REGS * ELEMS_PER_REG),
    localparam int VL_WIDTH     = VADDR_WIDTH + 1,
    localparam int VS_WIDTH     = $clog2(NR_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [VS_WIDTH-1:0]    req_vs_i,
    input  logic [VL_WIDTH-1:0]    req_vl_i,
    output logic [VADDR_WIDTH-1:0] vrf_raddr_o,
    output logic                   vrf_re_o,
    input  logic [ELEM_WIDTH-1:0]  vrf_rdata_i,
    input  logic                   vrf_rvalid_i,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic [ELEM_WIDTH-1:0]  data_o,
    output logic                   data_last_o,
    output logic                   busy_o
);

    localparam int NR_ELEMS  = NR_REGS * ELEMS_PER_REG;
    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [VADDR_WIDTH-1:0] addr_q, addr_d;
    logic [VL_WIDTH-1:0]    rem_q, rem_d;

    logic [ELEM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic                   fifo_last_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   fifo_empty, fifo_full, push, pop;

    assign fifo_empty   = (cnt_q == '0);
    assign fifo_full    = (cnt_q == CNT_WIDTH'(FIFO_DEPTH));
    assign data_valid_o = !fifo_empty;
    assign pop          = data_valid_o && data_ready_i;
    assign data_o       = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    assign data_last_o  = fifo_empty ? 1'b0 : fifo_last_q[rd_ptr_q];
    assign vrf_raddr_o  = (state_q == READ) ? addr_q : '0;
    assign busy_o       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        req_ready_o = 1'b0;
        vrf_re_o    = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d = VADDR_WIDTH'(req_vs_i) * VADDR_WIDTH'(ELEMS_PER_REG);
                    rem_d  = req_vl_i;
                    if (req_vl_i != '0) state_d = READ;
                end
            end
            READ: begin
                // Occupancy is the registered count; a same-cycle pop does not open a slot.
                vrf_re_o = !fifo_full;
                if (vrf_re_o && vrf_rvalid_i) begin
                    push   = 1'b1;
                    addr_d = (addr_q == VADDR_WIDTH'(NR_ELEMS - 1)) ? '0
                                                                    : addr_q + VADDR_WIDTH'(1);
                    rem_d  = rem_q - VL_WIDTH'(1);
                    if (rem_q == VL_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty || (cnt_q == CNT_WIDTH'(1) && pop)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0
                                                                     : wr_ptr_q + PTR_WIDTH'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0
                                                                     : rd_ptr_q + PTR_WIDTH'(1);
            if (push && !pop)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    // Storage needs no reset: the count gates everything visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= vrf_rdata_i;
            fifo_last_q[wr_ptr_q] <= (rem_q == VL_WIDTH'(1));
        end
    end

endmodule

// File: tb/tb_spatz_vrf_reader.sv
// tb/tb_spatz_vrf_reader.sv - directed table-driven bench for spatz_vrf_reader
module tb_spatz_vrf_reader;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_vs;
    logic [7:0]  req_vl;
    logic [6:0]  vrf_raddr;
    logic        vrf_re;
    logic [63:0] vrf_rdata;
    logic        vrf_rvalid;
    logic        data_valid;
    logic        data_ready;
    logic [63:0] data;
    logic        data_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    spatz_vrf_reader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_vs_i     (req_vs),
        .req_vl_i     (req_vl),
        .vrf_raddr_o  (vrf_raddr),
        .vrf_re_o     (vrf_re),
        .vrf_rdata_i  (vrf_rdata),
        .vrf_rvalid_i (vrf_rvalid),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .data_o       (data),
        .data_last_o  (data_last),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] vrf_val(input logic [6:0] a);
        return 64'hC0DE_0000_0000_0000 | ({57'd0, a} << 16) | {57'd0, ~a};
    endfunction

    assign vrf_rdata = vrf_val(vrf_raddr);

    function automatic logic [6:0] elem_addr(input int vs, input int i);
        return 7'((vs * 4 + i) % 128);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int vs;
        int vl;
        int hold;
        int off_s;
        int off_e;
        int exp_idle;
        int exp_re;
    } vec_t;

    vec_t tbl[7];

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, " vrf_re"}, 64'(vrf_re), 64'd0);
        chk({tag, " vrf_raddr"}, 64'(vrf_raddr), 64'd0);
        chk({tag, " data_valid"}, 64'(data_valid), 64'd0);
        chk({tag, " data"}, data, 64'd0);
        chk({tag, " data_last"}, 64'(data_last), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_req(input string tag, input vec_t v);
        int acc = 0;
        int got = 0;
        int addr_err = 0;
        int hold_err = 0;
        int idle_cyc = -1;
        int first_re = -1;
        int first_dv = -1;
        int re_early = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_vs    = 5'(v.vs);
        req_vl    = 8'(v.vl);
        for (int c = 0; c < 80; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            data_ready = (c >= v.hold);
            vrf_rvalid = !(c >= v.off_s && c <= v.off_e);
            #1;
            if (c == 0) chk({tag, " req_ready_c0"}, 64'(req_ready), 64'd1);
            if (c > 0 && req_ready && !data_valid) begin
                idle_cyc = c;
                break;
            end
            if (vrf_re) begin
                if (first_re < 0) first_re = c;
                if (c < 10) re_early++;
                if (acc >= v.vl || vrf_raddr !== elem_addr(v.vs, acc)) addr_err++;
                if (vrf_rvalid) acc++;
            end
            if (data_valid) begin
                if (first_dv < 0) first_dv = c;
                if (got >= v.vl) begin
                    hold_err++;
                end else if (!data_ready) begin
                    if (data !== vrf_val(elem_addr(v.vs, got))) hold_err++;
                end else begin
                    chk($sformatf("%s data[%0d]", tag, got), data, vrf_val(elem_addr(v.vs, got)));
                    chk($sformatf("%s last[%0d]", tag, got), 64'(data_last),
                        64'(got == v.vl - 1));
                    got++;
                end
            end
        end
        chk({tag, " idle_cycle"}, 64'(idle_cyc), 64'(v.exp_idle));
        chk({tag, " busy_at_idle"}, 64'(busy), 64'd0);
        chk({tag, " elems_out"}, 64'(got), 64'(v.vl));
        chk({tag, " reads_accepted"}, 64'(acc), 64'(v.vl));
        chk({tag, " raddr_seq_errs"}, 64'(addr_err), 64'd0);
        chk({tag, " hold_errs"}, 64'(hold_err), 64'd0);
        chk({tag, " re_cycles_lt10"}, 64'(re_early), 64'(v.exp_re));
        chk({tag, " first_re_cycle"}, 64'(first_re), 64'((v.vl > 0) ? 1 : -1));
        chk({tag, " first_dv_cycle"}, 64'(first_dv), 64'((v.vl > 0) ? 2 : -1));
    endtask

    initial begin
        int got;
        vec_t v6;
        tbl[0] = '{vs: 2,  vl: 4, hold: 0,  off_s: -1, off_e: -1, exp_idle: 6,  exp_re: 4};
        tbl[1] = '{vs: 3,  vl: 6, hold: 0,  off_s: -1, off_e: -1, exp_idle: 8,  exp_re: 6};
        tbl[2] = '{vs: 0,  vl: 8, hold: 10, off_s: -1, off_e: -1, exp_idle: 18, exp_re: 2};
        tbl[3] = '{vs: 0,  vl: 4, hold: 0,  off_s: 2,  off_e: 4,  exp_idle: 9,  exp_re: 7};
        tbl[4] = '{vs: 31, vl: 8, hold: 0,  off_s: -1, off_e: -1, exp_idle: 10, exp_re: 8};
        tbl[5] = '{vs: 5,  vl: 0, hold: 0,  off_s: -1, off_e: -1, exp_idle: 1,  exp_re: 0};
        tbl[6] = '{vs: 7,  vl: 1, hold: 0,  off_s: -1, off_e: -1, exp_idle: 3,  exp_re: 1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_vs     = '0;
        req_vl     = '0;
        vrf_rvalid = 1'b1;
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_req($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of an 8-element transfer, after two elements left.
        @(negedge clk);
        req_valid  = 1'b1;
        req_vs     = 5'd0;
        req_vl     = 8'd8;
        data_ready = 1'b1;
        vrf_rvalid = 1'b1;
        got        = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            #1;
            if (data_valid) got++;
        end
        chk("midrst elems_before", 64'(got), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (data_valid || vrf_re || busy) got++;
        end
        chk("midrst quiet_after", 64'(got), 64'd0);

        v6 = '{vs: 1, vl: 2, hold: 0, off_s: -1, off_e: -1, exp_idle: 4, exp_re: 2};
        run_req("postrst", v6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
